sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
- REQ-001: Parameter WIDTH, default 8, is the parallel word width; legal range 2..64.
- REQ-002: Parameter LSB_FIRST, default 1; 1 means the first serial bit lands in out_data[0], and 0 means it lands in out_data[WIDTH-1].
- REQ-003: clk  input  1  the single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: in_bit  input  1  serial data bit.
- REQ-006: in_valid  input  1  in_bit is captured on this edge; always accepted, with no serial backpressure.
- REQ-007: out_data  output  WIDTH  the assembled word, held stable while out_valid=1.
- REQ-008: out_valid  output  1  out_data holds an unconsumed word.
- REQ-009: out_ready  input  1  the consumer accepts the word when out_valid && out_ready.
- REQ-010: overrun  output  1  one-cycle pulse when a completed word is dropped.
- REQ-011: parity_err  output  1  present only with SIPO_PARITY_EN; qualified by out_valid.

Function
- REQ-012: On each edge with in_valid=1, the block shall shift in_bit into the shift register in the direction set by LSB_FIRST and increment the bit counter.
- REQ-013: The bit counter shall be $clog2(FRAME+1) bits wide, where FRAME = WIDTH, or WIDTH+1 with parity.
- REQ-014: On the edge that captures bit FRAME, the counter shall return to 0 and the word shall be completed.
- REQ-015: The block shall be able to accept the next frame's first bit on the following edge, with zero gap cycles.
- REQ-016: When a word completes, it shall be loaded into the holding register, and out_valid shall rise on that same edge (visible the cycle after the last bit).
- REQ-017: A transfer (out_valid && out_ready) shall clear out_valid on that edge unless a word completes on the same edge.
- REQ-018: If a word completes on the same edge as a transfer, the new word shall be loaded and out_valid shall stay 1.
- REQ-019: If a word completes while out_valid=1 and out_ready=0, the new word shall be dropped, out_data shall be unchanged, and overrun shall pulse for exactly one cycle.
- REQ-020: out_data shall change only when a word is loaded into the holding register.
- REQ-021: Cycles with in_valid=0 shall leave the shift register and counter unchanged, with no timeout.

Reset
- REQ-022: While rst=1, the shift register, counter and out_data shall be 0, and out_valid, overrun and parity_err shall be 0.
- REQ-023: A reset asserted mid-frame shall discard the partial word; the first in_valid bit after reset is bit 0 of a new frame.
- REQ-024: rst shall take priority over in_valid and out_ready on the same edge.

Configuration
- REQ-025: The macro SIPO_PARITY_EN shall control an even-parity check.
- REQ-026: When SIPO_PARITY_EN is defined, each frame shall be WIDTH data bits followed by one even-parity bit.
- REQ-027: When SIPO_PARITY_EN is defined, parity_err shall be loaded with out_data and shall be 1 when the XOR of the data bits and the parity bit is 1.
- REQ-028: When SIPO_PARITY_EN is defined, a word with a parity error shall still be delivered.
- REQ-029: When SIPO_PARITY_EN is undefined, the frame shall be WIDTH bits, the parity_err port shall not exist, and no parity logic shall be generated.

Structure
- REQ-030: The shared package sipo_pkg shall hold the FRAME and counter-width derivation functions and the LSB_FIRST/MSB_FIRST constants.
- REQ-031: The sub-module sipo_shift_core shall contain the shift register, bit counter and word-complete strobe.
- REQ-032: The top level shall contain the holding register, the handshake, overrun and parity.

Verification
- REQ-033: WIDTH=8, LSB_FIRST=1, bits of 0xA5 sent LSB first on consecutive cycles, out_ready=1 -> out_data=0xA5, with out_valid high for 1 cycle starting the cycle after the 8th bit.
- REQ-034: WIDTH=8, LSB_FIRST=0, bits 1,0,1,1,0,0,1,0 sent -> out_data=0xB2.
- REQ-035: out_ready=0, words 0x11 then 0x22 sent -> out_data=0x11 held, out_valid=1, overrun pulses once at completion of 0x22.
- REQ-036: out_valid=1 with 0x33, out_ready raised on the edge that completes 0x44 -> out_data=0x44, out_valid stays 1, no overrun.
- REQ-037: 5 bits sent, rst for 1 cycle, then 0x0F sent -> out_data=0x0F, with no stale bits.
- REQ-038: With SIPO_PARITY_EN, 0x07 sent with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1, and the word is still delivered.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared constants and frame-size derivations for the serial-to-parallel deserializer.
// The parity variant is selected by defining SIPO_PARITY_EN.
package sipo_pkg;

  localparam int SIPO_LSB_FIRST = 1;
  localparam int SIPO_MSB_FIRST = 0;

`ifdef SIPO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Serial bits per frame: the data bits plus an optional trailing parity bit.
  function automatic int frame_len(input int width, input bit par_en);
    return par_en ? width + 1 : width;
  endfunction

  function automatic int cnt_width(input int frame);
    return $clog2(frame + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial shift register and bit counter; flags the edge that captures the last frame bit.
// frame_o is the next-state register contents, so the completed frame is usable on that same edge.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int FRAME     = 8,
  parameter int LSB_FIRST = SIPO_LSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic [FRAME-1:0] frame_o,
  output logic             done_o
);

  localparam int                CNT_W = cnt_width(FRAME);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME - 1);

  logic [FRAME-1:0] sr_d, sr_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    done_o = 1'b0;
    if (in_valid) begin
      // LSB-first enters at the top and drifts down so the first bit ends in bit 0.
      if (LSB_FIRST == SIPO_LSB_FIRST) begin
        sr_d = {in_bit, sr_q[FRAME-1:1]};
      end else begin
        sr_d = {sr_q[FRAME-2:0], in_bit};
      end
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign frame_o = sr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with a one-word holding register and ready/valid output.
// Defining SIPO_PARITY_EN adds a trailing even-parity bit per frame and the parity_err output.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = SIPO_LSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int FRAME = frame_len(WIDTH, PARITY_EN);

  logic [FRAME-1:0] frame;
  logic             done;
  logic [WIDTH-1:0] word;
  logic             load;

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  logic             overrun_d, overrun_q;

  sipo_shift_core #(
    .FRAME    (FRAME),
    .LSB_FIRST(LSB_FIRST)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .in_bit  (in_bit),
    .in_valid(in_valid),
    .frame_o (frame),
    .done_o  (done)
  );

  // Data bits sit at the end of the frame the first bit arrived at; parity is the far end.
  generate
    if (LSB_FIRST == SIPO_LSB_FIRST) begin : g_lsb
      assign word = frame[WIDTH-1:0];
    end else begin : g_msb
      assign word = frame[FRAME-1 -: WIDTH];
    end
  endgenerate

  assign load = done && (!valid_q || out_ready);

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = done && valid_q && !out_ready;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      data_d  = word;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

`ifdef SIPO_PARITY_EN
  logic par_err_d, par_err_q;

  // Even parity over data plus parity bit: any odd count is an error.
  always_comb begin
    par_err_d = par_err_q;
    if (load) begin
      par_err_d = ^frame;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign parity_err = par_err_q;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: one LSB-first and one MSB-first instance share the stimulus.
module tb_sipo_deser;

`ifdef SIPO_PARITY_EN
  localparam int FRAME_TB = 9;
`else
  localparam int FRAME_TB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] lsb_data, msb_data;
  logic       lsb_valid, msb_valid;
  logic       lsb_ovr, msb_ovr;
`ifdef SIPO_PARITY_EN
  logic       lsb_perr, msb_perr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .out_data  (lsb_data),
    .out_valid (lsb_valid),
    .out_ready (out_ready),
    .overrun   (lsb_ovr)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err(lsb_perr)
`endif
  );

  sipo_deser #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .out_data  (msb_data),
    .out_valid (msb_valid),
    .out_ready (out_ready),
    .overrun   (msb_ovr)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err(msb_perr)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame; returns 1 time unit after the edge that captures the last frame bit.
  task automatic send_word(input logic [7:0] w, input bit lsb, input int gap_at,
                           input bit ready_last, input bit bad_par);
    logic b;
    for (int i = 0; i < FRAME_TB; i++) begin
      if (i < 8) b = lsb ? w[i] : w[7-i];
      else       b = (^w) ^ bad_par;
      if (ready_last && i == FRAME_TB - 1) out_ready = 1'b1;
      in_valid = 1'b1;
      in_bit   = b;
      tick();
      if (i == gap_at) begin
        in_valid = 1'b0;
        in_bit   = ~b;
        repeat (3) tick();
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    tick();
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    out_ready = 1'b1;
    repeat (2) tick();
    check("rst_valid", lsb_valid, 0);
    check("rst_data",  lsb_data,  0);
    check("rst_ovr",   lsb_ovr,   0);
    check("rst_mdata", msb_data,  0);
`ifdef SIPO_PARITY_EN
    check("rst_perr",  lsb_perr,  0);
`endif
    rst      = 1'b0;
    in_valid = 1'b0;

    send_word(8'hA5, 1'b1, -1, 1'b0, 1'b0);
    check("a5_valid", lsb_valid, 1);
    check("a5_data",  lsb_data,  8'hA5);
    tick();
    check("a5_pulse", lsb_valid, 0);
    check("a5_hold",  lsb_data,  8'hA5);

    send_word(8'hB2, 1'b0, -1, 1'b0, 1'b0);
    check("b2_msb",   msb_data,  8'hB2);
    check("b2_mval",  msb_valid, 1);
    check("b2_lsb",   lsb_data,  8'h4D);
    tick();

    send_word(8'h3C, 1'b1, 3, 1'b0, 1'b0);
    check("gap_data",  lsb_data,  8'h3C);
    check("gap_valid", lsb_valid, 1);
    tick();

    out_ready = 1'b0;
    send_word(8'h11, 1'b1, -1, 1'b0, 1'b0);
    check("w11_ovr",   lsb_ovr,   0);
    check("w11_data",  lsb_data,  8'h11);
    send_word(8'h22, 1'b1, -1, 1'b0, 1'b0);
    check("ovr_pulse", lsb_ovr,   1);
    check("ovr_data",  lsb_data,  8'h11);
    check("ovr_valid", lsb_valid, 1);
    tick();
    check("ovr_clear", lsb_ovr,   0);
    check("ovr_hold",  lsb_data,  8'h11);

    out_ready = 1'b1;
    tick();
    check("drain_valid", lsb_valid, 0);
    out_ready = 1'b0;

    send_word(8'h33, 1'b1, -1, 1'b0, 1'b0);
    check("w33_data", lsb_data, 8'h33);
    send_word(8'h44, 1'b1, -1, 1'b1, 1'b0);
    check("w44_data",  lsb_data,  8'h44);
    check("w44_valid", lsb_valid, 1);
    check("w44_ovr",   lsb_ovr,   0);
    tick();
    check("w44_taken", lsb_valid, 0);

    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    check("mid_rst_data", lsb_data, 0);
    rst = 1'b0;
    send_word(8'h0F, 1'b1, -1, 1'b0, 1'b0);
    check("w0f_data",  lsb_data,  8'h0F);
    check("w0f_valid", lsb_valid, 1);
    tick();

`ifdef SIPO_PARITY_EN
    send_word(8'h07, 1'b1, -1, 1'b0, 1'b0);
    check("par_ok_err",  lsb_perr, 0);
    check("par_ok_data", lsb_data, 8'h07);
    tick();
    send_word(8'h07, 1'b1, -1, 1'b0, 1'b1);
    check("par_bad_err",   lsb_perr,  1);
    check("par_bad_valid", lsb_valid, 1);
    check("par_bad_data",  lsb_data,  8'h07);
    check("par_bad_merr",  msb_perr,  1);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
